inst_fetcher: RTL

Instruction fetch stage that drives the memory controller's instruction-fetch path and buffers the returned 32-bit instructions for the decoder. It owns the fetch PC, issues one fetch request at a time to the memory controller, and captures each assembled instruction on the controller's one-cycle ready pulse. Captured instructions go into a small circular queue, tagged with their PC. A redirect from the back end flushes the queue and discards any fetch still in flight.

---
 rtl/inst_fetcher.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: owns the fetch PC, issues one memory fetch at a time and
// buffers returned instructions, tagged with their PC, in a circular queue for decode.
module inst_fetcher #(
    parameter int          QLOG     = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst_in,
    input  logic        mem_inst_rdy,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int             DEPTH = 1 << QLOG;
    localparam logic [QLOG:0]  FULL  = (QLOG+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t          state, state_nxt;
    logic [31:0]     pc;
    logic [QLOG-1:0] head, tail;
    logic [QLOG:0]   count;
    entry_t          queue [DEPTH];

    logic issue, push, pop, done;
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            // The controller cannot abort a transfer, so a redirect mid-fetch
            // must wait out the response before the new PC can issue.
            WAIT: begin
                if (mem_inst_rdy)  state_nxt = IDLE;
                else if (redirect) state_nxt = DISCARD;
            end
            DISCARD: if (mem_inst_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        done  = 1'b0;
        case (state)
            // Issuing only below FULL reserves the slot for the in-flight fetch.
            IDLE:    issue = !redirect && (count != FULL);
            WAIT: begin
                done = mem_inst_rdy;
                push = mem_inst_rdy && !redirect;
            end
            DISCARD: done = mem_inst_rdy;
            default: ;
        endcase
    end

    assign pop = dec_valid && dec_ready && !redirect;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            pc       <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (rdy) begin
            if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= pc;
            end else if (done) begin
                mem_req  <= 1'b0;
            end

            if (redirect)
                pc <= {redirect_pc[31:2], 2'b00};
            else if (push)
                pc <= pc + 32'd4;

            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && push)
            queue[tail] <= '{pc: pc, inst: mem_inst_in};
    end

    assign dec_valid = (count != '0);
    assign dec_inst  = queue[head].inst;
    assign dec_pc    = queue[head].pc;

endmodule
